// File: rtl/uart_rx_frontend_if.sv
// ============================================================================
//  uart_rx_frontend_if
//  Received-byte stream and line status from the UART receiver front end.
//  Rev 1.0
// ============================================================================
`default_nettype none

interface uart_rx_frontend_if;
  logic       rxDataOutValid;
  logic [7:0] rxDataOut;
  logic       frameErr;
  logic       breakDet;
  logic       rxBusy;

  modport master (
    output rxDataOutValid,
    output rxDataOut,
    output frameErr,
    output breakDet,
    output rxBusy
  );

  modport slave (
    input rxDataOutValid,
    input rxDataOut,
    input frameErr,
    input breakDet,
    input rxBusy
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_frontend.sv
// ============================================================================
//  uart_rx_frontend
//  8N1 UART receiver: synchroniser, glitch reject, mid-bit sampling, break.
//  Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 234,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  wire logic              clk,
  input  wire logic              resetn,
  input  wire logic              rxIn,
  uart_rx_frontend_if.master     byteIf
);

  localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(HALF_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    WAITIDLE = 3'd4
  } state_t;

  state_t               state;
  logic                 rxMeta;
  logic                 rxSync;
  logic [c_CNT_W-1:0]   cnt;
  logic [2:0]           bitIdx;
  logic [7:0]           shReg;
  logic [7:0]           dataReg;
  logic                 validReg;
  logic                 frameErrReg;
  logic                 breakReg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      rxMeta      <= 1'b1;
      rxSync      <= 1'b1;
      cnt         <= '0;
      bitIdx      <= 3'd0;
      shReg       <= 8'h00;
      dataReg     <= 8'h00;
      validReg    <= 1'b0;
      frameErrReg <= 1'b0;
      breakReg    <= 1'b0;
    end else begin
      rxMeta      <= rxIn;
      rxSync      <= rxMeta;
      validReg    <= 1'b0;
      frameErrReg <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxSync) begin
            state <= START;
          end
        end

        // A start bit that is gone by mid-bit is treated as line noise.
        START: begin
          if (cnt == c_HALF_LAST) begin
            cnt <= '0;
            if (rxSync) begin
              state <= IDLE;
            end else begin
              state  <= DATA;
              bitIdx <= 3'd0;
            end
          end else begin
            cnt <= cnt + c_CNT_ONE;
          end
        end

        DATA: begin
          if (cnt == c_BIT_LAST) begin
            cnt   <= '0;
            shReg <= {rxSync, shReg[7:1]};
            if (bitIdx == 3'd7) begin
              state <= STOP;
            end else begin
              bitIdx <= bitIdx + 3'd1;
            end
          end else begin
            cnt <= cnt + c_CNT_ONE;
          end
        end

        // Leaving at mid-stop-bit lets the next start edge be seen on time.
        STOP: begin
          if (cnt == c_BIT_LAST) begin
            cnt <= '0;
            if (rxSync) begin
              dataReg  <= shReg;
              validReg <= 1'b1;
              state    <= IDLE;
            end else begin
              frameErrReg <= 1'b1;
              breakReg    <= (shReg == 8'h00);
              state       <= WAITIDLE;
            end
          end else begin
            cnt <= cnt + c_CNT_ONE;
          end
        end

        WAITIDLE: begin
          cnt <= '0;
          if (rxSync) begin
            breakReg <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign byteIf.rxDataOutValid = validReg;
  assign byteIf.rxDataOut      = dataReg;
  assign byteIf.frameErr       = frameErrReg;
  assign byteIf.breakDet       = breakReg;
  assign byteIf.rxBusy         = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
// ============================================================================
//  tb_uart_rx_frontend
//  Scoreboard bench: default-divider and CLKS_PER_BIT=4 receivers side by side.
//  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_frontend;

  localparam int CPB0  = 234;
  localparam int HALF0 = CPB0 / 2;
  localparam int CPB1  = 4;
  localparam int HALF1 = CPB1 / 2;

  logic clk = 1'b0;
  logic resetn;
  logic rxLine0;
  logic rxLine1;

  always #5 clk = ~clk;

  uart_rx_frontend_if if0 ();
  uart_rx_frontend_if if1 ();

  uart_rx_frontend #(.CLKS_PER_BIT(CPB0)) dut0 (
    .clk    (clk),
    .resetn (resetn),
    .rxIn   (rxLine0),
    .byteIf (if0)
  );

  uart_rx_frontend #(.CLKS_PER_BIT(CPB1)) dut1 (
    .clk    (clk),
    .resetn (resetn),
    .rxIn   (rxLine1),
    .byteIf (if1)
  );

  typedef struct {
    logic       isErr;
    logic [7:0] data;
    logic       brk;
    int         expCyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] lastData0;

  always @(posedge clk) cyc++;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every valid or frameErr pulse must match the head of its scoreboard.
  always @(negedge clk) begin
    if (if0.rxDataOutValid || if0.frameErr) begin
      checkVal("excl0", {31'd0, if0.rxDataOutValid & if0.frameErr}, 32'd0);
      if (q0.size() == 0) begin
        checkVal("unexp0", {30'd0, if0.rxDataOutValid, if0.frameErr}, 32'd0);
      end else begin
        e0 = q0.pop_front();
        checkVal("kind0", {31'd0, if0.frameErr}, {31'd0, e0.isErr});
        checkVal("data0", {24'd0, if0.rxDataOut}, {24'd0, e0.data});
        checkVal("brk0", {31'd0, if0.breakDet}, {31'd0, e0.brk});
        if (e0.expCyc >= 0) checkVal("lat0", cyc, e0.expCyc);
      end
    end
  end

  always @(negedge clk) begin
    if (if1.rxDataOutValid || if1.frameErr) begin
      checkVal("excl1", {31'd0, if1.rxDataOutValid & if1.frameErr}, 32'd0);
      if (q1.size() == 0) begin
        checkVal("unexp1", {30'd0, if1.rxDataOutValid, if1.frameErr}, 32'd0);
      end else begin
        e1 = q1.pop_front();
        checkVal("kind1", {31'd0, if1.frameErr}, {31'd0, e1.isErr});
        checkVal("data1", {24'd0, if1.rxDataOut}, {24'd0, e1.data});
        checkVal("brk1", {31'd0, if1.breakDet}, {31'd0, e1.brk});
        if (e1.expCyc >= 0) checkVal("lat1", cyc, e1.expCyc);
      end
    end
  end

  task automatic setLine(input int inst, input logic v);
    if (inst == 0) rxLine0 = v;
    else           rxLine1 = v;
  endtask

  task automatic idle(input int inst, input int n);
    setLine(inst, 1'b1);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; returns on the falling edge where the stop bit ends.
  task automatic sendFrame(input int inst, input logic [7:0] data, input logic stopBit);
    int         cpb;
    logic [9:0] bits;
    cpb  = (inst == 0) ? CPB0 : CPB1;
    bits = {stopBit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      setLine(inst, bits[b]);
      repeat (cpb) @(negedge clk);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "Valid"}, {31'd0, if0.rxDataOutValid}, 32'd0);
    checkVal({tag, "Data"},  {24'd0, if0.rxDataOut},      32'd0);
    checkVal({tag, "FErr"},  {31'd0, if0.frameErr},       32'd0);
    checkVal({tag, "Brk"},   {31'd0, if0.breakDet},       32'd0);
    checkVal({tag, "Busy"},  {31'd0, if0.rxBusy},         32'd0);
  endtask

  initial begin
    int c;
    logic [7:0] seq [3];
    seq = '{8'h1B, 8'h5B, 8'h41};

    resetn  = 1'b0;
    rxLine0 = 1'b1;
    rxLine1 = 1'b1;
    repeat (4) @(negedge clk);
    checkResetOutputs("rst");
    resetn    = 1'b1;
    lastData0 = 8'h00;
    idle(0, 10);

    // Single ESC frame with exact output latency.
    q0.push_back('{1'b0, 8'h1B, 1'b0, cyc + 3 + HALF0 + 9 * CPB0});
    sendFrame(0, 8'h1B, 1'b1);
    lastData0 = 8'h1B;
    idle(0, CPB0);

    // Back-to-back "ESC [ A" with no idle between frames.
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{1'b0, seq[i], 1'b0, -1});
      sendFrame(0, seq[i], 1'b1);
    end
    lastData0 = 8'h41;
    idle(0, 2 * CPB0);
    checkVal("b2bDrain", q0.size(), 32'd0);

    // Glitch shorter than half a bit.
    setLine(0, 1'b0);
    c = cyc;
    repeat (10) @(negedge clk);
    checkVal("glBusy", {31'd0, if0.rxBusy}, 32'd1);
    repeat (40) @(negedge clk);
    setLine(0, 1'b1);
    while (cyc < c + HALF0 + 3) @(negedge clk);
    checkVal("glIdle", {31'd0, if0.rxBusy}, 32'd0);
    idle(0, CPB0);

    // Framing error, then a good frame.
    q0.push_back('{1'b1, lastData0, 1'b0, cyc + 3 + HALF0 + 9 * CPB0});
    sendFrame(0, 8'h55, 1'b0);
    idle(0, 2 * CPB0);
    q0.push_back('{1'b0, 8'hA5, 1'b0, -1});
    sendFrame(0, 8'hA5, 1'b1);
    lastData0 = 8'hA5;
    idle(0, CPB0);

    // Break: 20 bit times low.
    q0.push_back('{1'b1, lastData0, 1'b1, -1});
    setLine(0, 1'b0);
    repeat (20 * CPB0) @(negedge clk);
    checkVal("brkHi", {31'd0, if0.breakDet}, 32'd1);
    setLine(0, 1'b1);
    @(negedge clk);
    checkVal("brkHold", {31'd0, if0.breakDet}, 32'd1);
    repeat (3) @(negedge clk);
    checkVal("brkClr", {31'd0, if0.breakDet}, 32'd0);
    idle(0, CPB0);
    checkVal("brkDrain", q0.size(), 32'd0);

    // Reset during bit 4 of a 0xFF frame.
    setLine(0, 1'b0);
    repeat (CPB0) @(negedge clk);
    setLine(0, 1'b1);
    repeat (4 * CPB0 + CPB0 / 2) @(negedge clk);
    checkVal("midBusy", {31'd0, if0.rxBusy}, 32'd1);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    checkResetOutputs("midRst");
    lastData0 = 8'h00;
    idle(0, 12 * CPB0);

    // Small divider: extreme byte values.
    idle(1, 8);
    q1.push_back('{1'b0, 8'h00, 1'b0, cyc + 3 + HALF1 + 9 * CPB1});
    sendFrame(1, 8'h00, 1'b1);
    q1.push_back('{1'b0, 8'hFF, 1'b0, -1});
    sendFrame(1, 8'hFF, 1'b1);
    q1.push_back('{1'b0, 8'h1B, 1'b0, -1});
    sendFrame(1, 8'h1B, 1'b1);
    idle(1, 20 * CPB1);

    checkVal("q0left", q0.size(), 32'd0);
    checkVal("q1left", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
